// File: rtl/priv_trap_pkg.sv
// Shared types, cause codes and fixed trap priority orders for the privilege trap controller.
package priv_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TAKE = 2'd2
    } trap_state_t;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int unsigned NUM_STD_INT    = 12;
    localparam int unsigned NUM_STD_EX     = 16;
    localparam int unsigned INT_STD_RANKED = 6;
    localparam int unsigned EX_STD_RANKED  = 14;

    localparam int unsigned IRQ_SSI = 1;
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_STI = 5;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_SEI = 9;
    localparam int unsigned IRQ_MEI = 11;

    localparam int unsigned EXC_IADDR_MIS = 0;
    localparam int unsigned EXC_IACC      = 1;
    localparam int unsigned EXC_ILLEGAL   = 2;
    localparam int unsigned EXC_BREAK     = 3;
    localparam int unsigned EXC_LADDR_MIS = 4;
    localparam int unsigned EXC_LACC      = 5;
    localparam int unsigned EXC_SADDR_MIS = 6;
    localparam int unsigned EXC_SACC      = 7;
    localparam int unsigned EXC_ECALL_U   = 8;
    localparam int unsigned EXC_ECALL_S   = 9;
    localparam int unsigned EXC_ECALL_M   = 11;
    localparam int unsigned EXC_IPF       = 12;
    localparam int unsigned EXC_LPF       = 13;
    localparam int unsigned EXC_SPF       = 15;

    // Interrupt line at rank pos (0 = highest): local lines high-index first, then standard order.
    function automatic int unsigned int_line_at(input int unsigned pos, input int unsigned num_int);
        int unsigned n_loc;
        n_loc = num_int - NUM_STD_INT;
        if (pos < n_loc) return num_int - 1 - pos;
        case (pos - n_loc)
            0:       return IRQ_MEI;
            1:       return IRQ_MSI;
            2:       return IRQ_MTI;
            3:       return IRQ_SEI;
            4:       return IRQ_SSI;
            default: return IRQ_STI;
        endcase
    endfunction

    // Exception cause at rank pos (0 = highest); custom causes follow in ascending order.
    function automatic int unsigned ex_cause_at(input int unsigned pos);
        if (pos >= EX_STD_RANKED) return NUM_STD_EX + (pos - EX_STD_RANKED);
        case (pos)
            0:       return EXC_BREAK;
            1:       return EXC_IPF;
            2:       return EXC_IACC;
            3:       return EXC_ILLEGAL;
            4:       return EXC_IADDR_MIS;
            5:       return EXC_ECALL_U;
            6:       return EXC_ECALL_S;
            7:       return EXC_ECALL_M;
            8:       return EXC_SADDR_MIS;
            9:       return EXC_LADDR_MIS;
            10:      return EXC_SPF;
            11:      return EXC_LPF;
            12:      return EXC_SACC;
            default: return EXC_LACC;
        endcase
    endfunction

endpackage

// File: rtl/priv_trap_prio_enc.sv
// Fixed-order priority encoder: bit 0 of the request vector is the highest priority.
module priv_trap_prio_enc #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid_c,
    output logic [IW-1:0] o_idx_c
);

    always_comb begin
        o_valid_c = 1'b0;
        o_idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid_c = 1'b1;
                o_idx_c   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Trap controller: sticky interrupt pending, prioritised selection, pipe-drain wait and CSR inject pulses.
module priv_trap_ctrl
    import priv_trap_pkg::*;
#(
    parameter int unsigned NUM_INT = 16,
    parameter int unsigned NUM_EX  = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_INT-1:0] int_set,
    input  logic [NUM_INT-1:0] int_clr,
    input  logic [NUM_EX-1:0]  ex_src,
    input  logic [NUM_INT-1:0] mideleg,
    input  logic [NUM_EX-1:0]  medeleg,
    input  logic [NUM_INT-1:0] mie,
    input  logic               mstatus_mie,
    input  logic               mstatus_sie,
    input  logic [1:0]         priv,
    input  logic               pipe_clear,
    input  logic               ex_mem_stall,
    input  logic [XLEN-1:0]    epc,
    input  logic [XLEN-1:0]    tval_in,
    output logic [NUM_INT-1:0] mip,
    output logic               intr,
    output logic               intr_to_s,
    output logic [XLEN-1:0]    cause,
    output logic [XLEN-1:0]    next_epc,
    output logic [XLEN-1:0]    next_tval,
    output logic               inject_m,
    output logic               inject_s
);

    localparam int unsigned INT_ORD = NUM_INT - NUM_STD_INT + INT_STD_RANKED;
    localparam int unsigned EX_ORD  = NUM_EX - NUM_STD_EX + EX_STD_RANKED;
    localparam int unsigned IPW     = $clog2(INT_ORD);
    localparam int unsigned EPW     = $clog2(EX_ORD);
    localparam int unsigned ILW     = $clog2(NUM_INT);
    localparam int unsigned ELW     = $clog2(NUM_EX);

    trap_state_t        r_state;
    logic [NUM_INT-1:0] r_mip;
    logic [ILW-1:0]     r_lat_line;
    logic               r_lat_to_s;
    logic [XLEN-1:0]    r_lat_epc;
    logic               r_intr, r_intr_to_s, r_inject_m, r_inject_s;
    logic [XLEN-1:0]    r_cause, r_next_epc, r_next_tval;

    logic               w_m_ok, w_s_ok;
    logic [NUM_INT-1:0] w_int_to_s, w_int_elig;
    logic [INT_ORD-1:0] w_int_ord;
    logic [EX_ORD-1:0]  w_ex_ord;
    logic [NUM_EX-1:0]  w_ex_req;
    logic               w_int_valid, w_ex_valid;
    logic [IPW-1:0]     w_int_pos;
    logic [EPW-1:0]     w_ex_pos;
    logic [ILW-1:0]     w_int_line;
    logic [ELW-1:0]     w_ex_line;
    logic               w_ex_to_s;

    // Global enable gating for each possible interrupt target mode
    assign w_m_ok = (priv != PRIV_M) || mstatus_mie;
    assign w_s_ok = (priv == PRIV_U) || ((priv == PRIV_S) && mstatus_sie);

    for (genvar i = 0; i < NUM_INT; i++) begin : g_int_elig
        assign w_int_to_s[i] = mideleg[i] && (priv != PRIV_M);
        assign w_int_elig[i] = r_mip[i] && mie[i] && (w_int_to_s[i] ? w_s_ok : w_m_ok);
    end

    for (genvar p = 0; p < INT_ORD; p++) begin : g_int_ord
        localparam int unsigned LINE = int_line_at(p, NUM_INT);
        assign w_int_ord[p] = w_int_elig[LINE];
    end

    assign w_ex_req = ex_mem_stall ? '0 : ex_src;

    for (genvar p = 0; p < EX_ORD; p++) begin : g_ex_ord
        localparam int unsigned CODE = ex_cause_at(p);
        assign w_ex_ord[p] = w_ex_req[CODE];
    end

    priv_trap_prio_enc #(.N(INT_ORD)) u_int_enc (
        .i_req     (w_int_ord),
        .o_valid_c (w_int_valid),
        .o_idx_c   (w_int_pos)
    );

    priv_trap_prio_enc #(.N(EX_ORD)) u_ex_enc (
        .i_req     (w_ex_ord),
        .o_valid_c (w_ex_valid),
        .o_idx_c   (w_ex_pos)
    );

    assign w_int_line = ILW'(int_line_at(32'(w_int_pos), NUM_INT));
    assign w_ex_line  = ELW'(ex_cause_at(32'(w_ex_pos)));
    assign w_ex_to_s  = medeleg[w_ex_line] && (priv != PRIV_M);

    function automatic logic [XLEN-1:0] mk_cause(input logic is_int, input logic [4:0] code);
        mk_cause           = '0;
        mk_cause[XLEN-1]   = is_int;
        mk_cause[4:0]      = code;
    endfunction

    // Pending capture and trap FSM; inject outputs are 1-cycle pulses while in TAKE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_mip       <= '0;
            r_lat_line  <= '0;
            r_lat_to_s  <= 1'b0;
            r_lat_epc   <= '0;
            r_intr      <= 1'b0;
            r_intr_to_s <= 1'b0;
            r_inject_m  <= 1'b0;
            r_inject_s  <= 1'b0;
            r_cause     <= '0;
            r_next_epc  <= '0;
            r_next_tval <= '0;
        end else begin
            r_mip       <= int_set | (r_mip & ~int_clr);
            r_intr      <= 1'b0;
            r_intr_to_s <= 1'b0;
            r_inject_m  <= 1'b0;
            r_inject_s  <= 1'b0;
            r_cause     <= '0;
            r_next_epc  <= '0;
            r_next_tval <= '0;
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (w_ex_valid) begin
                        r_state     <= ST_TAKE;
                        r_intr      <= 1'b1;
                        r_intr_to_s <= w_ex_to_s;
                        r_inject_s  <= w_ex_to_s;
                        r_inject_m  <= !w_ex_to_s;
                        r_cause     <= mk_cause(1'b0, 5'(w_ex_line));
                        r_next_epc  <= epc;
                        r_next_tval <= tval_in;
                    end else if (r_state == ST_IDLE) begin
                        if (w_int_valid) begin
                            r_state    <= ST_WAIT;
                            r_lat_line <= w_int_line;
                            r_lat_to_s <= w_int_to_s[w_int_line];
                            r_lat_epc  <= epc;
                        end
                    end else if (!w_int_elig[r_lat_line]) begin
                        r_state <= ST_IDLE;
                    end else if (pipe_clear) begin
                        r_state     <= ST_TAKE;
                        r_intr      <= 1'b1;
                        r_intr_to_s <= r_lat_to_s;
                        r_inject_s  <= r_lat_to_s;
                        r_inject_m  <= !r_lat_to_s;
                        r_cause     <= mk_cause(1'b1, 5'(r_lat_line));
                        r_next_epc  <= r_lat_epc;
                        r_next_tval <= '0;
                    end
                end
                ST_TAKE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mip       = r_mip;
    assign intr      = r_intr;
    assign intr_to_s = r_intr_to_s;
    assign cause     = r_cause;
    assign next_epc  = r_next_epc;
    assign next_tval = r_next_tval;
    assign inject_m  = r_inject_m;
    assign inject_s  = r_inject_s;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Self-checking bench for priv_trap_ctrl: directed scenarios plus randomized run against a trap model.
module tb_priv_trap_ctrl;

    localparam int unsigned NI = 20;
    localparam int unsigned NE = 20;
    localparam int unsigned XL = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] int_set, int_clr, mideleg, mie;
    logic [NE-1:0] ex_src, medeleg;
    logic          mstatus_mie, mstatus_sie, pipe_clear, ex_mem_stall;
    logic [1:0]    priv;
    logic [XL-1:0] epc, tval_in;
    logic [NI-1:0] mip;
    logic          intr, intr_to_s, inject_m, inject_s;
    logic [XL-1:0] cause, next_epc, next_tval;

    int checks   = 0;
    int failures = 0;

    int int_rank[$];
    int ex_rank[$];

    // Trap model state and expected outputs
    logic [NI-1:0] m_mip;
    bit            m_wait, m_to_s;
    int            m_line;
    logic [XL-1:0] m_epc;
    bit            e_intr, e_to_s;
    logic [XL-1:0] e_cause, e_epc, e_tval;

    priv_trap_ctrl #(.NUM_INT(NI), .NUM_EX(NE), .XLEN(XL)) dut (
        .CLK(clk), .RST(rst), .int_set(int_set), .int_clr(int_clr), .ex_src(ex_src),
        .mideleg(mideleg), .medeleg(medeleg), .mie(mie), .mstatus_mie(mstatus_mie),
        .mstatus_sie(mstatus_sie), .priv(priv), .pipe_clear(pipe_clear),
        .ex_mem_stall(ex_mem_stall), .epc(epc), .tval_in(tval_in), .mip(mip), .intr(intr),
        .intr_to_s(intr_to_s), .cause(cause), .next_epc(next_epc), .next_tval(next_tval),
        .inject_m(inject_m), .inject_s(inject_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        int_set = '0; int_clr = '0; ex_src = '0; mideleg = '0; medeleg = '0; mie = '0;
        mstatus_mie = 1'b0; mstatus_sie = 1'b0; priv = 2'd3; pipe_clear = 1'b0;
        ex_mem_stall = 1'b0; epc = '0; tval_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic build_ranks();
        int std_int[6];
        int std_ex[14];
        std_int = '{11, 3, 7, 9, 1, 5};
        std_ex  = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
        for (int l = int'(NI) - 1; l >= 12; l--) int_rank.push_back(l);
        foreach (std_int[k]) int_rank.push_back(std_int[k]);
        foreach (std_ex[k]) ex_rank.push_back(std_ex[k]);
        for (int c = 16; c < int'(NE); c++) ex_rank.push_back(c);
    endtask

    function automatic bit m_elig(input int i);
        bit to_s;
        to_s = mideleg[i] && (priv != 2'd3);
        if (!(m_mip[i] && mie[i])) return 1'b0;
        if (to_s) return (priv == 2'd0) || ((priv == 2'd1) && mstatus_sie);
        return (priv != 2'd3) || mstatus_mie;
    endfunction

    // Advance the model across the next clock edge using the currently driven inputs
    task automatic model_step();
        bit in_take;
        bit found;
        in_take = e_intr;
        e_intr = 0; e_to_s = 0; e_cause = '0; e_epc = '0; e_tval = '0;
        if (!in_take) begin
            found = 0;
            if (!ex_mem_stall) begin
                foreach (ex_rank[k]) begin
                    if (!found && ex_src[ex_rank[k]]) begin
                        found   = 1;
                        e_intr  = 1;
                        e_to_s  = medeleg[ex_rank[k]] && (priv != 2'd3);
                        e_cause = XL'(ex_rank[k]);
                        e_epc   = epc;
                        e_tval  = tval_in;
                        m_wait  = 0;
                    end
                end
            end
            if (!found && m_wait) begin
                if (!m_elig(m_line)) begin
                    m_wait = 0;
                end else if (pipe_clear) begin
                    e_intr  = 1;
                    e_to_s  = m_to_s;
                    e_cause = 32'h8000_0000 | XL'(m_line);
                    e_epc   = m_epc;
                    e_tval  = '0;
                    m_wait  = 0;
                end
            end else if (!found) begin
                foreach (int_rank[k]) begin
                    if (!found && m_elig(int_rank[k])) begin
                        found  = 1;
                        m_wait = 1;
                        m_line = int_rank[k];
                        m_to_s = mideleg[int_rank[k]] && (priv != 2'd3);
                        m_epc  = epc;
                    end
                end
            end
        end
        m_mip = int_set | (m_mip & ~int_clr);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mip !== '0) begin failures++; $display("FAIL reset_mip got=%h exp=0", mip); end
        checks++; if ({intr, intr_to_s, inject_m, inject_s} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {intr, intr_to_s, inject_m, inject_s});
        end
        checks++; if ({cause, next_epc, next_tval} !== '0) begin
            failures++; $display("FAIL reset_values cause=%h epc=%h tval=%h exp=0", cause, next_epc, next_tval);
        end
    endtask

    task automatic test_irq_wait();
        logic [XL-1:0] lat_epc;
        do_reset();
        priv = 2'd3; mstatus_mie = 1'b1; mie[7] = 1'b1;
        lat_epc = $urandom; epc = lat_epc;
        int_set[7] = 1'b1;
        tick();
        int_set = '0;
        tick();
        epc = $urandom;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (intr !== 1'b0) begin failures++; $display("FAIL irq_wait_hold%0d intr=%b exp=0", k, intr); end
        end
        pipe_clear = 1'b1;
        tick();
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL irq_take_intr got=%b exp=1", intr); end
        checks++; if (cause !== 32'h8000_0007) begin failures++; $display("FAIL irq_take_cause got=%h exp=80000007", cause); end
        checks++; if ({inject_m, inject_s, intr_to_s} !== 3'b100) begin
            failures++; $display("FAIL irq_take_target got=%b exp=100", {inject_m, inject_s, intr_to_s});
        end
        checks++; if (next_epc !== lat_epc) begin failures++; $display("FAIL irq_take_epc got=%h exp=%h", next_epc, lat_epc); end
        checks++; if (next_tval !== '0) begin failures++; $display("FAIL irq_take_tval got=%h exp=0", next_tval); end
        pipe_clear = 1'b0;
        tick();
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL irq_pulse_width intr=%b exp=0", intr); end
        checks++; if (mip[7] !== 1'b1) begin failures++; $display("FAIL irq_mip_kept got=%b exp=1", mip[7]); end
    endtask

    task automatic test_ex_prio();
        logic [XL-1:0] tv, pc;
        do_reset();
        priv = 2'd0; medeleg[3] = 1'b1;
        tv = $urandom; pc = $urandom; tval_in = tv; epc = pc;
        ex_src[2] = 1'b1; ex_src[3] = 1'b1;
        tick();
        ex_src = '0;
        checks++; if (intr !== 1'b1) begin failures++; $display("FAIL ex_prio_intr got=%b exp=1", intr); end
        checks++; if (cause !== 32'd3) begin failures++; $display("FAIL ex_prio_cause got=%h exp=3", cause); end
        checks++; if ({inject_m, inject_s, intr_to_s} !== 3'b011) begin
            failures++; $display("FAIL ex_prio_target got=%b exp=011", {inject_m, inject_s, intr_to_s});
        end
        checks++; if (next_tval !== tv) begin failures++; $display("FAIL ex_prio_tval got=%h exp=%h", next_tval, tv); end
        checks++; if (next_epc !== pc) begin failures++; $display("FAIL ex_prio_epc got=%h exp=%h", next_epc, pc); end
        tick();
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL ex_pulse_width intr=%b exp=0", intr); end
    endtask

    task automatic test_preempt();
        do_reset();
        priv = 2'd3; mstatus_mie = 1'b1; mie[11] = 1'b1;
        int_set[11] = 1'b1;
        tick();
        int_set = '0;
        tick();
        tick();
        checks++; if (intr !== 1'b0) begin failures++; $display("FAIL preempt_wait intr=%b exp=0", intr); end
        ex_src[8] = 1'b1; tval_in = 32'hDEAD_0008;
        tick();
        ex_src = '0;
        checks++; if (intr !== 1'b1 || cause !== 32'd8) begin
            failures++; $display("FAIL preempt_take intr=%b cause=%h exp=1/00000008", intr, cause);
        end
        checks++; if (next_tval !== 32'hDEAD_0008 || inject_m !== 1'b1) begin
            failures++; $display("FAIL preempt_tval tval=%h inject_m=%b exp=dead0008/1", next_tval, inject_m);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (intr !== 1'b0) begin failures++; $display("FAIL preempt_noirq%0d intr=%b exp=0", k, intr); end
        end
    endtask

    task automatic test_set_clr();
        do_reset();
        priv = 2'd3; mstatus_mie = 1'b1; mie[11] = 1'b1;
        int_set[11] = 1'b1; int_clr[11] = 1'b1;
        tick();
        int_set = '0;
        checks++; if (mip[11] !== 1'b1) begin failures++; $display("FAIL setclr_set_wins got=%b exp=1", mip[11]); end
        tick();
        int_clr = '0;
        checks++; if (mip[11] !== 1'b0) begin failures++; $display("FAIL setclr_cleared got=%b exp=0", mip[11]); end
        tick();
        pipe_clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (intr !== 1'b0) begin failures++; $display("FAIL setclr_abort%0d intr=%b exp=0", k, intr); end
        end
    endtask

    task automatic test_local_irq();
        do_reset();
        priv = 2'd0; mie[19] = 1'b1; mie[11] = 1'b1;
        int_set[19] = 1'b1; int_set[11] = 1'b1;
        tick();
        int_set = '0;
        tick();
        pipe_clear = 1'b1;
        tick();
        checks++; if (intr !== 1'b1 || cause !== 32'h8000_0013) begin
            failures++; $display("FAIL local_irq intr=%b cause=%h exp=1/80000013", intr, cause);
        end
        checks++; if (inject_m !== 1'b1 || inject_s !== 1'b0) begin
            failures++; $display("FAIL local_irq_target m=%b s=%b exp=1/0", inject_m, inject_s);
        end
    endtask

    task automatic test_rst_wait();
        do_reset();
        priv = 2'd3; mstatus_mie = 1'b1; mie[3] = 1'b1;
        int_set[3] = 1'b1;
        tick();
        int_set = '0;
        tick();
        pipe_clear = 1'b1; rst = 1'b1;
        tick();
        checks++; if (mip !== '0 || intr !== 1'b0) begin
            failures++; $display("FAIL rst_wait mip=%h intr=%b exp=0/0", mip, intr);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (intr !== 1'b0) begin failures++; $display("FAIL rst_wait_after%0d intr=%b exp=0", k, intr); end
        end
    endtask

    task automatic test_random();
        do_reset();
        m_mip = '0; m_wait = 0; m_to_s = 0; m_line = 0; m_epc = '0;
        e_intr = 0; e_to_s = 0; e_cause = '0; e_epc = '0; e_tval = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) begin
                mie = NI'($urandom); mideleg = NI'($urandom); medeleg = NE'($urandom);
                mstatus_mie = 1'($urandom); mstatus_sie = 1'($urandom);
                case ($urandom_range(0, 2))
                    0:       priv = 2'd0;
                    1:       priv = 2'd1;
                    default: priv = 2'd3;
                endcase
            end
            int_set = '0; int_clr = '0; ex_src = '0;
            if ($urandom_range(0, 5) == 0) int_set[$urandom_range(0, NI - 1)] = 1'b1;
            if ($urandom_range(0, 5) == 0) int_clr[$urandom_range(0, NI - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) ex_src = NE'($urandom) & NE'($urandom);
            ex_mem_stall = ($urandom_range(0, 3) == 0);
            pipe_clear   = 1'($urandom);
            epc = $urandom; tval_in = $urandom;
            model_step();
            tick();
            checks++; if (mip !== m_mip) begin failures++; $display("FAIL rnd_mip cyc=%0d got=%h exp=%h", cyc, mip, m_mip); end
            checks++; if (intr !== e_intr) begin failures++; $display("FAIL rnd_intr cyc=%0d got=%b exp=%b", cyc, intr, e_intr); end
            checks++; if (inject_m !== (e_intr && !e_to_s) || inject_s !== (e_intr && e_to_s)) begin
                failures++; $display("FAIL rnd_inject cyc=%0d m=%b s=%b exp=%b/%b", cyc, inject_m, inject_s, e_intr && !e_to_s, e_intr && e_to_s);
            end
            if (e_intr) begin
                checks++; if (cause !== e_cause || intr_to_s !== e_to_s) begin
                    failures++; $display("FAIL rnd_cause cyc=%0d got=%h/%b exp=%h/%b", cyc, cause, intr_to_s, e_cause, e_to_s);
                end
                checks++; if (next_epc !== e_epc || next_tval !== e_tval) begin
                    failures++; $display("FAIL rnd_epc_tval cyc=%0d got=%h/%h exp=%h/%h", cyc, next_epc, next_tval, e_epc, e_tval);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        build_ranks();
        test_reset();
        test_irq_wait();
        test_ex_prio();
        test_preempt();
        test_set_clr();
        test_local_irq();
        test_rst_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
